// File: rtl/ram_read_arbiter.sv
// Round-robin two-port read arbiter and burst sequencer in front of the RAM reader.
// One- or two-word bursts; each word is handed to its owner with a one-cycle valid pulse.
module ram_read_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RAM_LATENCY = 1   // legal range 1..4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  len0,
  output logic                  gnt0,
  output logic                  vld0,
  output logic [DATA_WIDTH-1:0] data0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  len1,
  output logic                  gnt1,
  output logic                  vld1,
  output logic [DATA_WIDTH-1:0] data1,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] am_out,
  input  logic [DATA_WIDTH-1:0] ram_out,
  output logic                  busy
);

  localparam int unsigned CntW = 2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic                  more_q, more_d;
  logic                  ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  read_d, gnt0_d, gnt1_d, vld0_d, vld1_d, busy_d;
  logic [ADDR_WIDTH-1:0] am_d;
  logic [DATA_WIDTH-1:0] data0_d, data1_d;
  logic                  win;

  // A lone requester wins outright; the pointer only breaks ties.
  assign win = (req0 && req1) ? ptr_q : req1;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    more_d  = more_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    read_d  = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
    busy_d  = busy;
    am_d    = am_out;
    data0_d = data0;
    data1_d = data1;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          port_d  = win;
          more_d  = win ? len1 : len0;
          am_d    = win ? addr1 : addr0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          read_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(RAM_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (port_q) begin
            data1_d = ram_out;
            vld1_d  = 1'b1;
          end else begin
            data0_d = ram_out;
            vld0_d  = 1'b1;
          end
          if (more_q) begin
            // Second word overlaps its ISSUE cycle with the first valid pulse.
            more_d  = 1'b0;
            am_d    = am_out + ADDR_WIDTH'(1);
            read_d  = 1'b1;
            state_d = StIssue;
          end else begin
            busy_d  = 1'b0;
            ptr_d   = ~port_q;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      more_q  <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      read    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      vld0    <= 1'b0;
      vld1    <= 1'b0;
      busy    <= 1'b0;
      am_out  <= '0;
      data0   <= '0;
      data1   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      more_q  <= more_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      read    <= read_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      vld0    <= vld0_d;
      vld1    <= vld1_d;
      busy    <= busy_d;
      am_out  <= am_d;
      data0   <= data0_d;
      data1   <= data1_d;
    end
  end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Bench for ram_read_arbiter: directed table, hand-written corner sequences and a
// randomized run against a transaction-level timing model, on L=1 and L=3 instances.
module tb_ram_read_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, len0, req1, len1;
  logic [9:0] addr0, addr1;
  logic       sel;

  logic        gnt0_a, vld0_a, gnt1_a, vld1_a, read_a, busy_a;
  logic        gnt0_b, vld0_b, gnt1_b, vld1_b, read_b, busy_b;
  logic [15:0] data0_a, data1_a, ram_a, data0_b, data1_b, ram_b;
  logic [9:0]  am_a, am_b;

  logic [15:0] mem [0:1023];
  logic [9:0]  pa [0:3];
  logic [9:0]  pb [0:3];

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] last0, last1;

  localparam int NE = 640;
  bit          e_g0 [0:NE-1];
  bit          e_g1 [0:NE-1];
  bit          e_v0 [0:NE-1];
  bit          e_v1 [0:NE-1];
  bit          e_rd [0:NE-1];
  bit          e_bz [0:NE-1];
  logic [9:0]  e_ad [0:NE-1];
  logic [15:0] e_wd [0:NE-1];

  always #5 clk = ~clk;

  ram_read_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RAM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0_a), .vld0(vld0_a), .data0(data0_a),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1_a), .vld1(vld1_a), .data1(data1_a),
    .read(read_a), .am_out(am_a), .ram_out(ram_a), .busy(busy_a)
  );

  ram_read_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RAM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0_b), .vld0(vld0_b), .data0(data0_b),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1_b), .vld1(vld1_b), .data1(data1_b),
    .read(read_b), .am_out(am_b), .ram_out(ram_b), .busy(busy_b)
  );

  // RAM reader models: address registered once per edge, data L edges after the read edge.
  always @(posedge clk) begin
    pa[0] <= am_a; pa[1] <= pa[0]; pa[2] <= pa[1]; pa[3] <= pa[2];
    pb[0] <= am_b; pb[1] <= pb[0]; pb[2] <= pb[1]; pb[3] <= pb[2];
  end
  assign ram_a = mem[pa[0]];
  assign ram_b = mem[pb[2]];

  logic        s_gnt0, s_gnt1, s_vld0, s_vld1, s_read, s_busy;
  logic [15:0] s_data0, s_data1;
  logic [9:0]  s_am;
  assign s_gnt0  = sel ? gnt0_b  : gnt0_a;
  assign s_gnt1  = sel ? gnt1_b  : gnt1_a;
  assign s_vld0  = sel ? vld0_b  : vld0_a;
  assign s_vld1  = sel ? vld1_b  : vld1_a;
  assign s_read  = sel ? read_b  : read_a;
  assign s_busy  = sel ? busy_b  : busy_a;
  assign s_data0 = sel ? data0_b : data0_a;
  assign s_data1 = sel ? data1_b : data1_a;
  assign s_am    = sel ? am_b    : am_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #3 rst = 0;
    last0 = 0; last1 = 0;
  endtask

  // One transaction on an idle DUT with latency l, checked cycle by cycle.
  task automatic txn(input logic p, input logic [9:0] a, input logic ln, input logic [15:0] w0,
                     input logic [15:0] w1, input int l, input string nm);
    logic [15:0] oth;
    logic [9:0]  a1;
    a1  = a + 10'd1;
    oth = p ? last0 : last1;
    if (p) begin req1 = 1; addr1 = a; len1 = ln; end
    else   begin req0 = 1; addr0 = a; len0 = ln; end
    @(posedge clk); #1;
    chk({nm, "_gnt"}, p ? s_gnt1 : s_gnt0, 1);
    chk({nm, "_gnt_other"}, p ? s_gnt0 : s_gnt1, 0);
    chk({nm, "_read"}, s_read, 1);
    chk({nm, "_am"}, s_am, a);
    chk({nm, "_busy"}, s_busy, 1);
    req0 = 0; req1 = 0;
    for (int w = 0; w < (ln ? 2 : 1); w++) begin
      repeat (l) begin
        @(posedge clk); #1;
        chk({nm, "_vld_early"}, p ? s_vld1 : s_vld0, 0);
        chk({nm, "_gnt_extra"}, p ? s_gnt1 : s_gnt0, 0);
        chk({nm, "_read_idle"}, s_read, 0);
      end
      @(posedge clk); #1;
      chk({nm, "_vld"}, p ? s_vld1 : s_vld0, 1);
      chk({nm, "_data"}, p ? s_data1 : s_data0, (w == 0) ? w0 : w1);
      if (w == 0 && ln) begin
        chk({nm, "_read2"}, s_read, 1);
        chk({nm, "_am2"}, s_am, a1);
      end
    end
    chk({nm, "_busy_end"}, s_busy, 0);
    chk({nm, "_data_other"}, p ? s_data0 : s_data1, oth);
    @(posedge clk); #1;
    chk({nm, "_vld_pulse"}, p ? s_vld1 : s_vld0, 0);
    if (p) last1 = ln ? w1 : w0;
    else   last0 = ln ? w1 : w0;
  endtask

  // Transaction-level model: each grant at edge n fixes every later event by arithmetic on L.
  task automatic run_random(input int ncyc);
    int          l, free, nb;
    logic        ptr, wp, ln, g;
    logic [9:0]  a, a1, mam;
    logic [15:0] md0, md1;
    l = sel ? 3 : 1; free = 0; ptr = 0; mam = 0; md0 = 0; md1 = 0; wp = 0;
    for (int i = 0; i < NE; i++) begin
      e_g0[i] = 0; e_g1[i] = 0; e_v0[i] = 0; e_v1[i] = 0; e_rd[i] = 0; e_bz[i] = 0;
      e_ad[i] = 0; e_wd[i] = 0;
    end
    for (int n = 0; n < ncyc; n++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; len0 = 1'($urandom);
        addr0 = ($urandom_range(0, 7) == 0) ? 10'h3ff : 10'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; len1 = 1'($urandom);
        addr1 = ($urandom_range(0, 7) == 0) ? 10'h3ff : 10'($urandom);
      end
      g = 0;
      if (n >= free && (req0 || req1)) begin
        g  = 1;
        wp = (req0 && req1) ? ptr : req1;
        a  = wp ? addr1 : addr0;
        ln = wp ? len1 : len0;
        a1 = a + 10'd1;
        if (wp) e_g1[n] = 1; else e_g0[n] = 1;
        e_rd[n] = 1; e_ad[n] = a;
        if (wp) e_v1[n+1+l] = 1; else e_v0[n+1+l] = 1;
        e_wd[n+1+l] = mem[a];
        if (ln) begin
          e_rd[n+1+l] = 1; e_ad[n+1+l] = a1;
          if (wp) e_v1[n+2+2*l] = 1; else e_v0[n+2+2*l] = 1;
          e_wd[n+2+2*l] = mem[a1];
          nb = 2 + 2 * l; free = n + 3 + 2 * l;
        end else begin
          nb = 1 + l; free = n + 2 + l;
        end
        for (int k = n; k < n + nb; k++) e_bz[k] = 1;
        ptr = ~wp;
      end
      @(posedge clk); #1;
      if (g) begin
        if (wp) req1 = 0; else req0 = 0;
      end
      if (e_rd[n]) mam = e_ad[n];
      if (e_v0[n]) md0 = e_wd[n];
      if (e_v1[n]) md1 = e_wd[n];
      chk("rnd_gnt0", s_gnt0, e_g0[n]);
      chk("rnd_gnt1", s_gnt1, e_g1[n]);
      chk("rnd_vld0", s_vld0, e_v0[n]);
      chk("rnd_vld1", s_vld1, e_v1[n]);
      chk("rnd_read", s_read, e_rd[n]);
      chk("rnd_busy", s_busy, e_bz[n]);
      chk("rnd_am", s_am, mam);
      chk("rnd_data0", s_data0, md0);
      chk("rnd_data1", s_data1, md1);
    end
    req0 = 0; req1 = 0;
  endtask

  typedef struct {
    logic        p;
    logic [9:0]  a;
    logic        ln;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t tbl [6];
  int   gport [$];
  int   gcyc [$];

  initial begin
    tbl[0] = '{p: 1'b0, a: 10'h000, ln: 1'b0, w0: 16'h0304, w1: 16'h0000};
    tbl[1] = '{p: 1'b1, a: 10'h008, ln: 1'b1, w0: 16'he110, w1: 16'h0016};
    tbl[2] = '{p: 1'b0, a: 10'h3ff, ln: 1'b1, w0: 16'h5a5a, w1: 16'h0304};
    tbl[3] = '{p: 1'b1, a: 10'h002, ln: 1'b0, w0: 16'h4304, w1: 16'h0000};
    tbl[4] = '{p: 1'b0, a: 10'h009, ln: 1'b0, w0: 16'h0016, w1: 16'h0000};
    tbl[5] = '{p: 1'b1, a: 10'h004, ln: 1'b1, w0: 16'he304, w1: 16'h1234};

    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0304; mem[1] = 16'h000a; mem[2] = 16'h4304; mem[4] = 16'he304;
    mem[5] = 16'h1234; mem[8] = 16'he110; mem[9] = 16'h0016; mem[10'h3ff] = 16'h5a5a;

    sel = 0; rst = 1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; len0 = 0; len1 = 0;
    last0 = 0; last1 = 0;
    #2;
    chk("rst_gnt0", gnt0_a, 0);  chk("rst_gnt1", gnt1_a, 0);
    chk("rst_vld0", vld0_a, 0);  chk("rst_vld1", vld1_a, 0);
    chk("rst_read", read_a, 0);  chk("rst_busy", busy_a, 0);
    chk("rst_am", am_a, 0);      chk("rst_data0", data0_a, 0);
    chk("rst_data1", data1_a, 0);
    @(posedge clk); #3 rst = 0;

    for (int i = 0; i < 6; i++)
      txn(tbl[i].p, tbl[i].a, tbl[i].ln, tbl[i].w0, tbl[i].w1, 1, $sformatf("vec%0d", i));

    // Latency instance
    do_reset();
    sel = 1;
    txn(1'b0, 10'h001, 1'b0, 16'h000a, 16'h0000, 3, "lat_single");
    txn(1'b1, 10'h008, 1'b1, 16'he110, 16'h0016, 3, "lat_burst");
    sel = 0;

    // Round-robin with both requests held from reset
    req0 = 1; addr0 = 10'h002; len0 = 0;
    req1 = 1; addr1 = 10'h004; len1 = 0;
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #3 rst = 0;
    for (int c = 0; c < 40 && gport.size() < 4; c++) begin
      @(posedge clk); #1;
      if (gnt0_a) begin gport.push_back(0); gcyc.push_back(c); end
      if (gnt1_a) begin gport.push_back(1); gcyc.push_back(c); end
    end
    if (gport.size() < 4) begin
      n_chk++; n_fail++;
      $display("FAIL rr_timeout: got %0d grants expected 4", gport.size());
    end else begin
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), gport[i], i % 2);
      chk("rr_first", gcyc[0], 0);
      for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    chk("rr_data0", data0_a, 16'h4304);
    chk("rr_data1", data1_a, 16'he304);
    req0 = 0; req1 = 0;

    // Reset during WAIT of a port 1 burst, with the pointer moved to port 1 beforehand
    do_reset();
    txn(1'b0, 10'h000, 1'b0, 16'h0304, 16'h0000, 1, "pre_abort");
    req1 = 1; addr1 = 10'h008; len1 = 1;
    @(posedge clk); #1;
    chk("abort_gnt1", gnt1_a, 1);
    req1 = 0;
    @(posedge clk); #3 rst = 1;
    #1;
    chk("abort_read", read_a, 0); chk("abort_gnt0", gnt0_a, 0); chk("abort_gnt1r", gnt1_a, 0);
    chk("abort_vld0", vld0_a, 0); chk("abort_vld1", vld1_a, 0); chk("abort_busy", busy_a, 0);
    chk("abort_am", am_a, 0);     chk("abort_data0", data0_a, 0);
    @(posedge clk); #3 rst = 0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_vld1", vld1_a, 0);
    end
    req0 = 1; addr0 = 10'h000; len0 = 0;
    req1 = 1; addr1 = 10'h008; len1 = 0;
    @(posedge clk); #1;
    chk("abort_next_gnt0", gnt0_a, 1);
    chk("abort_next_gnt1", gnt1_a, 0);
    req0 = 0; req1 = 0;

    do_reset();
    sel = 0;
    run_random(500);
    do_reset();
    sel = 1;
    run_random(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
